regfile_wb_queue: RTL
=====================

// Module: regfile_wb_queue
// PURPOSE
//  Writeback initiator for the register file: collects results from the ALU/WB path and from
//  load returns (cache refills), buffers them in an in-order queue and drives the regfile
//  write port (A3/WD3/WE3) at one write per cycle. Also provides forwarding lookups so readers
//  see queued-but-unwritten values. Sits between the pipeline WB stage / cache and the regfile.
// PARAMETERS
//  DATA_WIDTH  32  width of register data
//  NUM_REGS    32  architectural registers; address width AW = $clog2(NUM_REGS)
//  DEPTH       4   queue entries (power of 2, >= 2)
// PORTS
//  clk         in   1           clock; all state updates on posedge
//  rst         in   1           synchronous, active-high reset
//  alu_valid   in   1           ALU result offered
//  alu_rd      in   AW          ALU destination register
//  alu_data    in   DATA_WIDTH  ALU result
//  alu_ready   out  1           ALU result accepted when alu_valid && alu_ready
//  mem_valid   in   1           load-return result offered
//  mem_rd      in   AW          load destination register
//  mem_data    in   DATA_WIDTH  load data
//  mem_ready   out  1           load accepted when mem_valid && mem_ready
//  A3          out  AW          regfile write address
//  WD3         out  DATA_WIDTH  regfile write data
//  WE3         out  1           regfile write enable
//  q_a1, q_a2  in   AW          forwarding query addresses (regfile A1/A2)
//  fwd1_hit    out  1           newer value for q_a1 pending in queue
//  fwd1_data   out  DATA_WIDTH  that value (0 when no hit)
//  fwd2_hit    out  1           as fwd1 for q_a2
//  fwd2_data   out  DATA_WIDTH  as fwd1 for q_a2
//  count       out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset: count=0, head/tail ptrs=0, WE3=0, A3=0, WD3=0, fwd*_hit=0, fwd*_data=0,
//   alu_ready=0, mem_ready=0 while rst high. Reset mid-operation discards all queued
//   entries; no WE3 in any cycle with rst high.
//  Readiness (depends only on registered count, never on valid): free = DEPTH - count;
//   mem_ready = !rst && free>=1; alu_ready = !rst && free>=2 (loads get priority slot).
//  Push: accepted mem entry enqueued first, then accepted ALU entry, same cycle (up to 2).
//   Entries with rd==0 are accepted (handshake completes) but NOT enqueued (x0 never written).
//  Pop/drive: WE3 = (count!=0); A3/WD3 = head entry, combinational from queue head; head
//   popped on every posedge where count!=0 and !rst. Write latency: 1 cycle min (push at
//   edge N -> WE3 during cycle N+1 if queue was empty).
//  count_next = count + pushes - pop; simultaneous push+pop on full queue legal (pop frees
//   nothing for same-cycle ready since ready uses registered count). No overflow possible.
//  Pointers wrap modulo DEPTH. Writes to regfile are in strict enqueue order.
//  Forwarding (combinational): search valid entries newest->oldest incl. head; hit on first
//   rd==q; data = that entry's data. q==0 -> hit=0, data=0. Does not see same-cycle pushes.
//  Empty: WE3=0, A3=0, WD3=0. Full: both readies 0.
// TESTING
//  1 rst 2 cycles, alu push rd=5 data=0xDEAD -> next cycle WE3=1 A3=5 WD3=0xDEAD, then WE3=0, count 0.
//  2 same-cycle mem rd=3 0x11 + alu rd=3 0x22 -> WE3 cycles: A3=3 WD3=0x11 then A3=3 WD3=0x22.
//  3 alu push rd=0 0xFFFF -> alu_ready handshake ok, count stays 0, WE3 never asserts.
//  4 fill to DEPTH=4 with no... (pop runs): hold mem_valid/alu_valid every cycle -> count
//    never exceeds 4, alu_ready=0 whenever count>=3, mem_ready=0 at count=4, no entry lost.
//  5 queue rd=7 0xA then rd=7 0xB, q_a1=7 -> fwd1_hit=1 fwd1_data=0xB; q_a2=0 -> hit 0.
//  6 3 entries queued, assert rst 1 cycle -> WE3=0 that cycle and after, count=0, no writes.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order writeback queue from ALU and load returns into the regfile write port, with forwarding lookups
module regfile_wb_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int DEPTH      = 4,
  localparam int AW = $clog2(NUM_REGS),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [AW-1:0]         alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [AW-1:0]         mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  output logic [AW-1:0]         A3,
  output logic [DATA_WIDTH-1:0] WD3,
  output logic                  WE3,
  input  logic [AW-1:0]         q_a1,
  input  logic [AW-1:0]         q_a2,
  output logic                  fwd1_hit,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic                  fwd2_hit,
  output logic [DATA_WIDTH-1:0] fwd2_data,
  output logic [CW-1:0]         count
);
  logic [AW-1:0]         rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]         head_q, tail_q, alu_idx, idx;
  logic [CW-1:0]         count_q;
  logic                  mem_push, alu_push, pop;
  // Loads only need one free slot; ALU needs two so a load can always land alongside it.
  assign mem_ready = !rst && (count_q < CW'(DEPTH));
  assign alu_ready = !rst && (count_q < CW'(DEPTH - 1));
  assign mem_push  = mem_valid && mem_ready && (mem_rd != '0);
  assign alu_push  = alu_valid && alu_ready && (alu_rd != '0);
  assign alu_idx   = tail_q + PW'(mem_push);
  assign pop       = !rst && (count_q != '0);
  assign WE3       = pop;
  assign A3        = pop ? rd_q[head_q] : '0;
  assign WD3       = pop ? data_q[head_q] : '0;
  assign count     = rst ? '0 : count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (mem_push) begin
        rd_q[tail_q]   <= mem_rd;
        data_q[tail_q] <= mem_data;
      end
      if (alu_push) begin
        rd_q[alu_idx]   <= alu_rd;
        data_q[alu_idx] <= alu_data;
      end
      head_q  <= head_q + PW'(pop);
      tail_q  <= tail_q + PW'(mem_push) + PW'(alu_push);
      count_q <= count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end
  end
  // Walk oldest to newest so the newest matching entry wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    idx       = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (!rst && CW'(i) < count_q && q_a1 != '0 && rd_q[idx] == q_a1) begin
        fwd1_hit  = 1'b1;
        fwd1_data = data_q[idx];
      end
      if (!rst && CW'(i) < count_q && q_a2 != '0 && rd_q[idx] == q_a2) begin
        fwd2_hit  = 1'b1;
        fwd2_data = data_q[idx];
      end
    end
  end
endmodule
